sst_sequencer: RTL
==================

Name: sst_sequencer

Overview:
- Initiator end of the save-state register bus (act/addr/we_reg/dato out, read data in) that every mapper IRQ/bank block answers on.
- Save: walks register addresses 0..N_REGS-1, samples each mapper read byte and streams it out on a valid/ready byte port.
- Load: pulls bytes from a valid/ready input stream and writes them back to the same addresses.
- Sits between the mapper core and the save-state DMA/host path.

Parameters:
- ADDR_W, 8, save-state address width.
- N_REGS, 64, number of consecutive addresses walked (0..N_REGS-1); legal range 1..2^ADDR_W.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- map_rst  in  1  synchronous, active-high reset.
- cmd_save  in  1  one-cycle start-save strobe.
- cmd_load  in  1  one-cycle start-load strobe.
- cmd_abort  in  1  abort the operation in progress.
- sst_act  out  1  save-state bus active; mapper freezes normal operation.
- sst_addr  out  ADDR_W  current register address.
- sst_we_reg  out  1  one-cycle register write strobe.
- sst_dato  out  8  write data to the mapper.
- sst_din  in  8  mapper read data; combinational function of sst_addr.
- so_data  out  8  save stream byte.
- so_valid  out  1  save byte valid.
- so_ready  in  1  save sink ready.
- si_data  in  8  load stream byte.
- si_valid  in  1  load byte valid.
- si_ready  out  1  load source ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at normal completion (not on abort).

Behaviour:
- Reset values: every output is 0. State is IDLE. The internal index is 0.
- States: IDLE, S_ADDR, S_OUT, L_IN, L_WR, FIN.
- IDLE:
  - cmd_save -> S_ADDR with index 0.
  - cmd_load -> L_IN with index 0.
  - If both are high, save wins.
  - sst_act rises on the cycle after the strobe and stays high until FIN is left.
- S_ADDR: sst_addr = index. Settle cycle. Next state is S_OUT, and sst_din is captured into so_data on that edge.
- S_OUT:
  - so_valid = 1. so_data is held stable while so_valid & !so_ready.
  - On so_valid & so_ready: if index == N_REGS-1 -> FIN; else index+1 -> S_ADDR.
  - Throughput is one byte per 2 cycles at so_ready = 1.
- L_IN:
  - si_ready = 1, sst_addr = index.
  - On si_valid & si_ready: capture si_data into sst_dato -> L_WR.
- L_WR: sst_we_reg = 1 for exactly this cycle. addr and dato are stable during it. Then, if index == N_REGS-1 -> FIN; else index+1 -> L_IN.
- FIN: done = 1 for one cycle. busy drops and sst_act drops on the next cycle. Next state is IDLE.
- Strobe handling:
  - cmd_save and cmd_load are ignored while busy.
  - A strobe in the FIN cycle is ignored.
- cmd_abort:
  - Any non-IDLE state -> IDLE on the next edge. No done pulse.
  - sst_act, so_valid, si_ready and sst_we_reg are 0 from that edge.
  - A byte in transfer during the abort cycle is not considered transferred.
  - Abort has priority over the stream handshake and over L_WR.
- Index rules: width ADDR_W, no wrap. The last address is exactly N_REGS-1. N_REGS = 1 gives a single-byte transfer.
- sst_addr holds its last value in IDLE; consumers must qualify it with sst_act.
- map_rst mid-operation gives the same result as abort, with all outputs at their reset values.

Optional Feature:
- SST_CHKSUM_EN defined:
  - An 8-bit running sum (mod 256) is kept of all register bytes. It is cleared on start.
  - Save: after the last register, one extra byte equal to the sum is streamed (state S_SUM, same handshake) before FIN.
  - Load: after the last write, one extra byte is accepted (state L_SUM). If it is not equal to the sum of loaded bytes, output chk_err (1 bit) is set in FIN. chk_err is cleared on the next start or on reset. done still pulses.
- Undefined: no extra byte, no chk_err port. Stream length is exactly N_REGS.

Test Plan:
- Save, N_REGS=4, mapper returns addr^8'hA5, so_ready=1 -> so_data A5,A4,A7,A6; done pulses once; sst_act high throughout, then low one cycle after done.
- Save with so_ready low for 5 cycles on byte 2 -> so_data held at A7 with so_valid high; no duplicated or lost bytes.
- Load 11,22,33,44 with si_valid gaps of 3 cycles -> exactly 4 sst_we_reg pulses, at addr 0..3 with dato 11..44; sst_we_reg never asserts while waiting.
- cmd_abort in S_OUT of byte 1 -> next cycle busy=0, sst_act=0, so_valid=0, no done; a following cmd_save restarts at addr 0.
- cmd_save and cmd_load in the same cycle -> save runs; a cmd_load issued mid-save is ignored; map_rst mid-load -> all outputs 0, no further writes.
- SST_CHKSUM_EN: save of 01,02,03,04 streams 0A as the 5th byte; load of 01,02,03,04,0B -> chk_err=1; load ending with 0A -> chk_err=0.

Source files
------------

// File: rtl/sst_sequencer_if.sv
// Save-state register bus plus the save (out) and load (in) byte streams of sst_sequencer.
// master is the sequencer side; slave is the mapper / stream endpoint side.
interface sst_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              sst_act;
    logic [ADDR_W-1:0] sst_addr;
    logic              sst_we_reg;
    logic [7:0]        sst_dato;
    logic [7:0]        sst_din;

    logic [7:0]        so_data;
    logic              so_valid;
    logic              so_ready;

    logic [7:0]        si_data;
    logic              si_valid;
    logic              si_ready;

    modport master (
        output sst_act, sst_addr, sst_we_reg, sst_dato,
        input  sst_din,
        output so_data, so_valid,
        input  so_ready,
        input  si_data, si_valid,
        output si_ready
    );

    modport slave (
        input  sst_act, sst_addr, sst_we_reg, sst_dato,
        output sst_din,
        input  so_data, so_valid,
        output so_ready,
        output si_data, si_valid,
        input  si_ready
    );
endinterface

// File: rtl/sst_sequencer.sv
// Save-state sequencer: walks mapper registers 0..N_REGS-1, streaming them out (save) or in (load).
// Define SST_CHKSUM_EN to append/verify an 8-bit running-sum byte and expose chk_err.
module sst_sequencer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned N_REGS = 64
) (
    input  logic             clk,
    input  logic             map_rst,
    input  logic             cmd_save,
    input  logic             cmd_load,
    input  logic             cmd_abort,
    sst_sequencer_if.master  bus,
    output logic             busy,
    output logic             done
`ifdef SST_CHKSUM_EN
    ,
    output logic             chk_err
`endif
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N_REGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSAddr,
        StSOut,
        StLIn,
        StLWr,
        StFin,
        StSSum,
        StLSum
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        so_data_q, so_data_d;
    logic [7:0]        dato_q, dato_d;
`ifdef SST_CHKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              chk_err_q, chk_err_d;
`endif

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            so_data_q <= '0;
            dato_q    <= '0;
`ifdef SST_CHKSUM_EN
            sum_q     <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            so_data_q <= so_data_d;
            dato_q    <= dato_d;
`ifdef SST_CHKSUM_EN
            sum_q     <= sum_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        so_data_d = so_data_q;
        dato_d    = dato_q;
`ifdef SST_CHKSUM_EN
        sum_d     = sum_q;
        chk_err_d = chk_err_q;
`endif
        // Abort beats any handshake or pending write; datapath is left untouched.
        if (cmd_abort && state_q != StIdle) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_save || cmd_load) begin
                        state_d = cmd_save ? StSAddr : StLIn;
                        idx_d   = '0;
`ifdef SST_CHKSUM_EN
                        sum_d     = '0;
                        chk_err_d = 1'b0;
`endif
                    end
                end
                StSAddr: begin
                    state_d   = StSOut;
                    so_data_d = bus.sst_din;
`ifdef SST_CHKSUM_EN
                    sum_d = sum_q + bus.sst_din;
`endif
                end
                StSOut: begin
                    if (bus.so_ready) begin
                        if (idx_q == LastIdx) begin
`ifdef SST_CHKSUM_EN
                            state_d   = StSSum;
                            so_data_d = sum_q;
`else
                            state_d = StFin;
`endif
                        end else begin
                            state_d = StSAddr;
                            idx_d   = idx_q + ADDR_W'(1);
                        end
                    end
                end
                StSSum: begin
                    if (bus.so_ready) state_d = StFin;
                end
                StLIn: begin
                    if (bus.si_valid) begin
                        state_d = StLWr;
                        dato_d  = bus.si_data;
`ifdef SST_CHKSUM_EN
                        sum_d = sum_q + bus.si_data;
`endif
                    end
                end
                StLWr: begin
                    if (idx_q == LastIdx) begin
`ifdef SST_CHKSUM_EN
                        state_d = StLSum;
`else
                        state_d = StFin;
`endif
                    end else begin
                        state_d = StLIn;
                        idx_d   = idx_q + ADDR_W'(1);
                    end
                end
                StLSum: begin
                    if (bus.si_valid) begin
                        state_d = StFin;
`ifdef SST_CHKSUM_EN
                        chk_err_d = (bus.si_data != sum_q);
`endif
                    end
                end
                StFin:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy           = (state_q != StIdle);
        done           = (state_q == StFin);
        bus.sst_act    = busy;
        bus.sst_addr   = idx_q;
        bus.sst_we_reg = (state_q == StLWr);
        bus.sst_dato   = dato_q;
        bus.so_data    = so_data_q;
        bus.so_valid   = (state_q == StSOut) || (state_q == StSSum);
        bus.si_ready   = (state_q == StLIn) || (state_q == StLSum);
`ifdef SST_CHKSUM_EN
        chk_err        = chk_err_q;
`endif
    end

endmodule
